// File: rtl/frac_n_pkg.sv
// Shared definitions for the fractional-N divider control path.
// FSM state constants and the divide-ratio clamp used by the divider and
// by MASH-adjacent blocks that need the same legal-ratio rule.
package frac_n_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Clamp a signed raw ratio into [n_min, 2^width_n-1].
  function automatic int frac_n_clamp(input int raw, input int width_n, input int n_min);
    int n_max;
    n_max = (1 << width_n) - 1;
    if (raw < n_min) begin
      return n_min;
    end else if (raw > n_max) begin
      return n_max;
    end
    return raw;
  endfunction

  // True when the raw ratio falls outside the legal range.
  function automatic logic frac_n_clamped(input int raw, input int width_n, input int n_min);
    int n_max;
    n_max = (1 << width_n) - 1;
    return (raw < n_min) || (raw > n_max);
  endfunction

endpackage

// File: rtl/frac_n_div_ctrl.sv
// Fractional-N divide-by-N controller.
// Each output period lasts clamp(n_int + mash_in) input clocks; div_out is
// high for ceil(R/2) cycles and low for floor(R/2). Periods run back to back
// while enabled; dropping enable lets the current period finish.
// Optional sticky clamp indicator: define FRAC_N_DIV_CLAMP_FLAG_EN.
// Handshake: none; n_int/mash_in are level inputs sampled only on the load
// edge that starts a period (count==0 in RUN with enable high).
module frac_n_div_ctrl
  import frac_n_pkg::*;
#(
  parameter int WIDTH_N = 8,
  parameter int ORDER   = 3,
  parameter int N_MIN   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic [WIDTH_N-1:0] i_n_int,
  input  logic [ORDER-1:0]   i_mash_in,
`ifdef FRAC_N_DIV_CLAMP_FLAG_EN
  input  logic               i_clamp_clr,
  output logic               o_clamp_flag,
`endif
  output logic               o_div_out,
  output logic               o_div_pulse,
  output logic [WIDTH_N-1:0] o_ratio_cur,
  output logic [0:0]         o_dbg_state
);

  localparam logic [WIDTH_N-1:0] ONE = {{(WIDTH_N-1){1'b0}}, 1'b1};

  logic [0:0]         r_state;
  logic [WIDTH_N-1:0] r_count;
  logic [WIDTH_N-1:0] r_hi_len;
  logic [WIDTH_N-1:0] r_ratio_cur;
  logic               r_div_out;
  logic               r_div_pulse;

  logic signed [WIDTH_N+1:0] w_raw;
  logic signed [31:0]        w_raw_int;
  logic [WIDTH_N-1:0]        w_ratio;
  logic [WIDTH_N-1:0]        w_hi_len;
  logic [WIDTH_N-1:0]        w_elapsed_next;
  logic                      w_clamped;
  logic                      w_load;

  // Offset is sign-extended, n_int zero-extended, two guard bits avoid overflow.
  assign w_raw = $signed({2'b00, i_n_int})
               + $signed({{(WIDTH_N+2-ORDER){i_mash_in[ORDER-1]}}, i_mash_in});
  assign w_raw_int = {{(32-WIDTH_N-2){w_raw[WIDTH_N+1]}}, w_raw};

  assign w_ratio   = WIDTH_N'(frac_n_clamp(w_raw_int, WIDTH_N, N_MIN));
  assign w_clamped = frac_n_clamped(w_raw_int, WIDTH_N, N_MIN);
  // ceil(R/2) without needing an extra bit for R+1.
  assign w_hi_len  = (w_ratio >> 1) + {{(WIDTH_N-1){1'b0}}, w_ratio[0]};
  // Cycle index within the period that the next edge enters.
  assign w_elapsed_next = r_ratio_cur - r_count;
  assign w_load = (r_state == ST_RUN) && (r_count == '0) && i_enable;

  // Main FSM: idle hold, period load, countdown with duty-cycle shaping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_hi_len    <= '0;
      r_ratio_cur <= '0;
      r_div_out   <= 1'b0;
      r_div_pulse <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_count     <= '0;
          r_div_out   <= 1'b0;
          r_div_pulse <= 1'b0;
          if (i_enable) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_count == '0) begin
            if (i_enable) begin
              r_ratio_cur <= w_ratio;
              r_count     <= w_ratio - ONE;
              r_hi_len    <= w_hi_len;
              r_div_pulse <= 1'b1;
              r_div_out   <= 1'b1;
            end else begin
              r_state     <= ST_IDLE;
              r_div_pulse <= 1'b0;
              r_div_out   <= 1'b0;
            end
          end else begin
            r_count     <= r_count - ONE;
            r_div_pulse <= 1'b0;
            r_div_out   <= (w_elapsed_next < r_hi_len);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FRAC_N_DIV_CLAMP_FLAG_EN
  logic r_clamp_flag;

  // Sticky clamp indicator; a clamp on the clearing edge keeps it set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clamp_flag <= 1'b0;
    end else if (w_load && w_clamped) begin
      r_clamp_flag <= 1'b1;
    end else if (i_clamp_clr) begin
      r_clamp_flag <= 1'b0;
    end
  end

  assign o_clamp_flag = r_clamp_flag;
`else
  logic w_unused_clamp;
  assign w_unused_clamp = w_clamped;
`endif

  assign o_div_out   = r_div_out;
  assign o_div_pulse = r_div_pulse;
  assign o_ratio_cur = r_ratio_cur;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_frac_n_div_ctrl.sv
// Testbench for frac_n_div_ctrl: period-level reference model plus
// directed scenarios with hand-computed period lengths and high times.
module tb_frac_n_div_ctrl;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [W-1:0] n_int;
  logic [2:0]   mash;
  logic         clamp_clr;
  logic         div_out;
  logic         div_pulse;
  logic [W-1:0] ratio_cur;
  logic [0:0]   dbg_state;
  logic         clamp_flag;

  always #5 clk = ~clk;

  frac_n_div_ctrl #(.WIDTH_N(W), .ORDER(3), .N_MIN(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_n_int     (n_int),
    .i_mash_in   (mash),
`ifdef FRAC_N_DIV_CLAMP_FLAG_EN
    .i_clamp_clr (clamp_clr),
    .o_clamp_flag(clamp_flag),
`endif
    .o_div_out   (div_out),
    .o_div_pulse (div_pulse),
    .o_ratio_cur (ratio_cur),
    .o_dbg_state (dbg_state)
  );

`ifndef FRAC_N_DIV_CLAMP_FLAG_EN
  assign clamp_flag = 1'b0;
`endif

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Each entry is one clk cycle of a period: {pulse, div_out, ratio}.
  logic [W+1:0] exp_q[$];
  logic         running = 1'b0;
  logic         e_pulse = 1'b0;
  logic         e_out   = 1'b0;
  logic [W-1:0] e_ratio = '0;
  logic         e_flag  = 1'b0;

  function automatic int raw_of(input logic [W-1:0] n, input logic [2:0] m);
    int mi;
    mi = m[2] ? int'(m) - 8 : int'(m);
    return int'(n) + mi;
  endfunction

  function automatic int ref_ratio(input int raw);
    if (raw < 4) return 4;
    if (raw > 255) return 255;
    return raw;
  endfunction

  // Reference: a load expands into R queued cycles; otherwise idle outputs.
  always @(posedge clk or negedge rst_n) begin : model
    logic [W+1:0] ent;
    int raw;
    int r;
    ent = '0;
    if (!rst_n) begin
      exp_q.delete();
      running = 1'b0;
      e_pulse = 1'b0;
      e_out   = 1'b0;
      e_ratio = '0;
      e_flag  = 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        if (clamp_clr) e_flag = 1'b0;
      end else if (running && enable) begin
        raw = raw_of(n_int, mash);
        r   = ref_ratio(raw);
        for (int i = 0; i < r; i++) begin
          exp_q.push_back({(i == 0), (i < (r + 1) / 2), W'(r)});
        end
        ent = exp_q.pop_front();
        if (raw != r) e_flag = 1'b1;
        else if (clamp_clr) e_flag = 1'b0;
      end else begin
        if (running) running = 1'b0;
        else if (enable) running = 1'b1;
        ent = {1'b0, 1'b0, e_ratio};
        if (clamp_clr) e_flag = 1'b0;
      end
      e_pulse = ent[W+1];
      e_out   = ent[W];
      e_ratio = ent[W-1:0];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Advance one cycle and compare all outputs against the model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    check("div_pulse", int'(div_pulse), int'(e_pulse));
    check("div_out", int'(div_out), int'(e_out));
    check("ratio_cur", int'(ratio_cur), int'(e_ratio));
`ifdef FRAC_N_DIV_CLAMP_FLAG_EN
    check("clamp_flag", int'(clamp_flag), int'(e_flag));
`endif
  endtask

  task automatic wait_pulse();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (div_pulse) found = 1'b1;
    end
    if (!found) check("wait_pulse_timeout", 0, 1);
  endtask

  // Starts at a pulse cycle; sets inputs for the next load, measures this period.
  task automatic measure(input int nn, input int mm, input int mid_at, input int mid_n,
                         input int exp_len, input int exp_hi, input string tag);
    int len;
    int hi;
    bit done;
    len  = 1;
    hi   = int'(div_out);
    done = 1'b0;
    n_int = W'(nn);
    mash  = 3'(mm);
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (div_pulse) begin
        done = 1'b1;
      end else begin
        len++;
        hi += int'(div_out);
        if (len == mid_at) n_int = W'(mid_n);
      end
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
    check({tag, "_len"}, len, exp_len);
    check({tag, "_hi"}, hi, exp_hi);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int highs;
    int pulses;
    rst_n     = 1'b1;
    enable    = 1'b0;
    n_int     = 8'd10;
    mash      = 3'd0;
    clamp_clr = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_div_out", int'(div_out), 0);
    check("rst_div_pulse", int'(div_pulse), 0);
    check("rst_ratio_cur", int'(ratio_cur), 0);
    check("rst_state", int'(dbg_state), 0);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;

    // Steady ratio 10, then MASH offsets +3, -4, +1.
    wait_pulse();
    check("first_ratio", int'(ratio_cur), 10);
    measure(10, 0, -1, 0, 10, 5, "r10_a");
    measure(10, 0, -1, 0, 10, 5, "r10_b");
    measure(10, 3, -1, 0, 10, 5, "r10_c");
    measure(10, -4, -1, 0, 13, 7, "r13");
    measure(10, 1, -1, 0, 6, 3, "r6");
    measure(10, 0, -1, 0, 11, 6, "r11");

    // Clamp low (5-4=1 -> 4) and high (254+3=257 -> 255).
    measure(5, -4, -1, 0, 10, 5, "r10_d");
`ifdef FRAC_N_DIV_CLAMP_FLAG_EN
    check("clamp_flag_set", int'(clamp_flag), 1);
`endif
    check("clamp_lo_ratio", int'(ratio_cur), 4);
    measure(254, 3, -1, 0, 4, 2, "r4");
    check("clamp_hi_ratio", int'(ratio_cur), 255);
    measure(10, 0, -1, 0, 255, 128, "r255");
    measure(7, 0, -1, 0, 10, 5, "r10_e");

    // n_int changes 7 -> 9 mid-period: current stays 7, next is 9.
    measure(7, 0, 3, 9, 7, 4, "r7");
    measure(12, 0, -1, 0, 9, 5, "r9");

    // Enable dropped at cycle 3 of a ratio-12 period.
    highs  = int'(div_out);
    pulses = 0;
    for (int i = 1; i < 40; i++) begin
      tick();
      if (i == 2) enable = 1'b0;
      highs  += int'(div_out);
      pulses += int'(div_pulse);
    end
    check("drop_highs", highs, 6);
    check("drop_pulses", pulses, 0);
    check("drop_state", int'(dbg_state), 0);
    enable = 1'b1;
    tick();
    check("reen_no_pulse_yet", int'(div_pulse), 0);
    tick();
    check("reen_pulse", int'(div_pulse), 1);
    check("reen_ratio", int'(ratio_cur), 12);

    // Asynchronous reset while div_out is high.
    tick();
    tick();
    check("pre_rst_out", int'(div_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", int'(div_out), 0);
    check("async_rst_pulse", int'(div_pulse), 0);
    check("async_rst_ratio", int'(ratio_cur), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_no_pulse", int'(div_pulse), 0);
    tick();
    check("post_rst_pulse", int'(div_pulse), 1);
    check("post_rst_ratio", int'(ratio_cur), 12);
    measure(12, 0, -1, 0, 12, 6, "r12");

`ifdef FRAC_N_DIV_CLAMP_FLAG_EN
    clamp_clr = 1'b1;
    tick();
    clamp_clr = 1'b0;
    check("clamp_flag_clr", int'(clamp_flag), 0);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
